// File: rtl/seq_checker_pkg.sv
// rtl/seq_checker_pkg.sv - shared state type, default sequence table and table lookup for seq_checker
package seq_pkg;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 1 << SYM_W;

    // Entry 0 in the LSBs: Gray order 0,1,3,2,6,7,5,4
    localparam logic [SYM_W*8-1:0] DEF_SEQ_TABLE =
        {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        SLIP   = 2'd2
    } state_e;

    typedef struct packed {
        logic             hit;
        logic [SYM_W-1:0] idx;
    } lookup_t;

    function automatic lookup_t seq_find(input logic [SYM_W*MAX_LEN-1:0] tbl,
                                         input int                       len,
                                         input logic [SYM_W-1:0]         sym);
        lookup_t r;
        r = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < len && !r.hit && tbl[i*SYM_W +: SYM_W] == sym) begin
                r.hit = 1'b1;
                r.idx = i[SYM_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_checker_if.sv
// rtl/seq_checker_if.sv - symbol stream and status bundle of seq_checker (capture fields under SEQ_CHECKER_CAPTURE_EN)
interface seq_checker_if #(
    parameter int SYM_W = 3,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [SYM_W-1:0] seq_in;
    logic             locked;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [IDX_W-1:0] exp_idx;
`ifdef SEQ_CHECKER_CAPTURE_EN
    logic [SYM_W-1:0] err_exp;
    logic [SYM_W-1:0] err_got;
    logic             err_seen;

    modport master (output in_valid, seq_in,
                    input  locked, mismatch, err_count, exp_idx, err_exp, err_got, err_seen);
    modport slave  (input  in_valid, seq_in,
                    output locked, mismatch, err_count, exp_idx, err_exp, err_got, err_seen);
`else
    modport master (output in_valid, seq_in,
                    input  locked, mismatch, err_count, exp_idx);
    modport slave  (input  in_valid, seq_in,
                    output locked, mismatch, err_count, exp_idx);
`endif
endinterface

// File: rtl/seq_checker_lookup.sv
// rtl/seq_checker_lookup.sv - combinational symbol-to-index CAM over the expected sequence table
module seq_lookup
    import seq_pkg::*;
#(
    parameter int                       SEQ_LEN   = 8,
    parameter logic [SYM_W*SEQ_LEN-1:0] SEQ_TABLE = DEF_SEQ_TABLE,
    parameter int                       IDX_W     = $clog2(SEQ_LEN)
) (
    input  logic [SYM_W-1:0] sym_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [SYM_W*MAX_LEN-1:0] TBL_EXT = (SYM_W*MAX_LEN)'(SEQ_TABLE);

    lookup_t res;

    assign res   = seq_find(TBL_EXT, SEQ_LEN, sym_i);
    assign hit_o = res.hit;
    assign idx_o = res.idx[IDX_W-1:0];

endmodule

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - sequence lock/slip checker; SEQ_CHECKER_CAPTURE_EN adds first-mismatch capture
module seq_checker
    import seq_pkg::*;
#(
    parameter int                       SYM_W      = 3,
    parameter int                       SEQ_LEN    = 8,
    parameter logic [SYM_W*SEQ_LEN-1:0] SEQ_TABLE  = DEF_SEQ_TABLE,
    parameter int                       LOCK_CNT   = 3,
    parameter int                       UNLOCK_CNT = 2,
    parameter int                       CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_checker_if.slave  bus
);

    localparam int IDX_W = $clog2(SEQ_LEN);

    state_e           state_q, state_d;
    logic             seeded_q, seeded_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             mm_q, mm_d;

    logic [SYM_W-1:0] exp_sym;
    logic             sym_ok;
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             count_err;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(SEQ_LEN - 1)) ? '0 : i + 1'b1;
    endfunction

    seq_lookup #(
        .SEQ_LEN   (SEQ_LEN),
        .SEQ_TABLE (SEQ_TABLE),
        .IDX_W     (IDX_W)
    ) u_lookup (
        .sym_i (bus.seq_in),
        .hit_o (lk_hit),
        .idx_o (lk_idx)
    );

    assign exp_sym = SEQ_TABLE[idx_q*SYM_W +: SYM_W];
    assign sym_ok  = (bus.seq_in == exp_sym);

    always_comb begin
        state_d   = state_q;
        seeded_d  = seeded_q;
        run_d     = run_q;
        miss_d    = miss_q;
        idx_d     = idx_q;
        err_d     = err_q;
        count_err = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (seeded_q && sym_ok) begin
                        idx_d = idx_inc(idx_q);
                        run_d = run_q + 4'd1;
                        if (run_d == 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        // Unseeded or broken run: restart phase search from this sample
                        run_d    = '0;
                        seeded_d = lk_hit;
                        if (lk_hit) begin
                            idx_d = idx_inc(lk_idx);
                        end
                    end
                end
                LOCKED, SLIP: begin
                    idx_d = idx_inc(idx_q);
                    if (sym_ok) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else begin
                        count_err = 1'b1;
                        miss_d    = miss_q + 4'd1;
                        if (miss_d == 4'(UNLOCK_CNT)) begin
                            state_d  = HUNT;
                            seeded_d = 1'b0;
                            miss_d   = '0;
                        end else begin
                            state_d = SLIP;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        mm_d = count_err;
        if (count_err && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            seeded_q <= 1'b0;
            run_q    <= '0;
            miss_q   <= '0;
            idx_q    <= '0;
            err_q    <= '0;
            mm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            seeded_q <= seeded_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            mm_q     <= mm_d;
        end
    end

    assign bus.locked    = (state_q != HUNT);
    assign bus.mismatch  = mm_q;
    assign bus.err_count = err_q;
    assign bus.exp_idx   = idx_q;

`ifdef SEQ_CHECKER_CAPTURE_EN
    logic             cap_seen_q;
    logic [SYM_W-1:0] cap_exp_q;
    logic [SYM_W-1:0] cap_got_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_seen_q <= 1'b0;
            cap_exp_q  <= '0;
            cap_got_q  <= '0;
        end else if (count_err && !cap_seen_q) begin
            cap_seen_q <= 1'b1;
            cap_exp_q  <= exp_sym;
            cap_got_q  <= bus.seq_in;
        end
    end

    assign bus.err_seen = cap_seen_q;
    assign bus.err_exp  = cap_exp_q;
    assign bus.err_got  = cap_got_q;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - scoreboard bench for seq_checker (default and CNT_W=2 instances side by side)
module tb_seq_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_checker_if #(.SYM_W(3), .IDX_W(3), .CNT_W(8)) a_if ();
    seq_checker_if #(.SYM_W(3), .IDX_W(3), .CNT_W(2)) b_if ();

    seq_checker #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(a_if));
    seq_checker #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(b_if));

    typedef struct {
        int locked;
        int mm;
        int err;
        int err2;
        int idx;
        int seen;
        int cexp;
        int cgot;
    } exp_t;

    exp_t sb[$];
    int   tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int   n_total = 0;
    int   n_bad   = 0;

    int m_st, m_seeded, m_run, m_miss, m_idx, m_err, m_err2, m_mm;
    int m_seen, m_cexp, m_cgot;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int find_sym(input int s);
        for (int i = 0; i < 8; i++) if (tab[i] == s) return i;
        return -1;
    endfunction

    task automatic model_clear();
        m_st = 0; m_seeded = 0; m_run = 0; m_miss = 0; m_idx = 0;
        m_err = 0; m_err2 = 0; m_mm = 0; m_seen = 0; m_cexp = 0; m_cgot = 0;
    endtask

    // Reference behaviour: 0=HUNT 1=LOCKED 2=SLIP, LOCK_CNT=3, UNLOCK_CNT=2
    task automatic model(input bit v, input int s);
        int e, f;
        m_mm = 0;
        if (!v) return;
        e = tab[m_idx];
        if (m_st == 0) begin
            if (m_seeded != 0 && s == e) begin
                m_run++;
                m_idx = (m_idx + 1) % 8;
                if (m_run == 3) begin m_st = 1; m_run = 0; end
            end else begin
                f = find_sym(s);
                m_run = 0;
                m_seeded = (f >= 0);
                if (f >= 0) m_idx = (f + 1) % 8;
            end
        end else begin
            m_idx = (m_idx + 1) % 8;
            if (s == e) begin
                m_st = 1; m_miss = 0;
            end else begin
                m_mm = 1;
                if (m_err < 255) m_err++;
                if (m_err2 < 3) m_err2++;
                if (m_seen == 0) begin m_seen = 1; m_cexp = e; m_cgot = s; end
                m_miss++;
                if (m_miss >= 2) begin m_st = 0; m_seeded = 0; m_miss = 0; end
                else m_st = 2;
            end
        end
    endtask

    task automatic drive(input bit v, input int s);
        a_if.in_valid = v; a_if.seq_in = 3'(s);
        b_if.in_valid = v; b_if.seq_in = 3'(s);
    endtask

    task automatic step(input bit v, input int s);
        exp_t e;
        drive(v, s);
        model(v, s);
        e = '{locked: (m_st != 0), mm: m_mm, err: m_err, err2: m_err2, idx: m_idx,
              seen: m_seen, cexp: m_cexp, cgot: m_cgot};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked", a_if.locked, e.locked);
        chk("mismatch", a_if.mismatch, e.mm);
        chk("err_count", a_if.err_count, e.err);
        chk("exp_idx", a_if.exp_idx, e.idx);
        chk("err_count_w2", b_if.err_count, e.err2);
        chk("mismatch_w2", b_if.mismatch, e.mm);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("err_seen", a_if.err_seen, e.seen);
        chk("err_exp", a_if.err_exp, e.cexp);
        chk("err_got", a_if.err_got, e.cgot);
`endif
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b1, 3);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_locked", a_if.locked, 0);
        chk("rst_mismatch", a_if.mismatch, 0);
        chk("rst_err", a_if.err_count, 0);
        chk("rst_idx", a_if.exp_idx, 0);
    endtask

    initial begin
        model_clear();
        drive(1'b0, 0);
        do_reset(2);

        // Acquire lock
        step(1, 0); step(1, 1); step(1, 3);
        step(1, 2);
        chk("lock_rise", a_if.locked, 1);
        chk("lock_idx", a_if.exp_idx, 4);
        step(1, 6);

        // Wrap-around
        step(1, 7); step(1, 5);
        step(1, 4);
        chk("wrap_idx", a_if.exp_idx, 0);
        step(1, 0); step(1, 1); step(1, 3); step(1, 2);

        // Single slip: expecting 6, feed 5 then 7
        step(1, 5);
        chk("slip_mm", a_if.mismatch, 1);
        chk("slip_err", a_if.err_count, 1);
        chk("slip_locked", a_if.locked, 1);
        step(1, 7);
        chk("slip_back", a_if.locked, 1);

        // Lock loss, then relock
        step(1, 0);
        step(1, 0);
        chk("loss_locked", a_if.locked, 0);
        chk("loss_err", a_if.err_count, 3);
        step(1, 5); step(1, 4); step(1, 0);
        step(1, 1);
        chk("relock", a_if.locked, 1);

        // Valid gating with garbage, then mid-run reset
        for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 7));
        chk("gate_idx", a_if.exp_idx, 2);
        chk("gate_locked", a_if.locked, 1);
        do_reset(1);

        // Saturation: alternate mismatches and matches while locked
        step(1, 0); step(1, 1); step(1, 3); step(1, 2);
        for (int i = 0; i < 5; i++) begin
            step(1, tab[(m_idx + 3) % 8]);
            step(1, tab[m_idx]);
        end
        chk("sat_err_w8", a_if.err_count, 5);
        chk("sat_err_w2", b_if.err_count, 3);
        chk("sat_locked", a_if.locked, 1);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("cap_exp", a_if.err_exp, 6);
        chk("cap_got", a_if.err_got, 4);
`endif

        // Mixed random traffic, mostly on-sequence
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 4) != 0) ? tab[m_idx] : int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side partner of the 3-bit sequence generator: monitors the generator's `out` stream and checks it against the expected cyclic sequence.
- Locks onto the sequence phase, flags every deviation, counts errors and drops lock on persistent slip.
- Sits beside the generator in self-checking benches and on-chip as a built-in self-test monitor.

Parameters:
- SYM_W, 3: symbol width; matches generator `out` width.
- SEQ_LEN, 8: number of entries in the expected cycle; range 2..2**SYM_W.
- SEQ_TABLE, {3'd4,3'd5,3'd7,3'd6,3'd2,3'd3,3'd1,3'd0}: packed expected sequence.
  - Entry 0 is in the LSBs, so the default sequence is Gray code 0,1,3,2,6,7,5,4.
  - Entries must be unique.
- LOCK_CNT, 3: consecutive correct predictions required to declare lock; range 1..15.
- UNLOCK_CNT, 2: consecutive mismatches that drop lock; range 1..15.
- CNT_W, 8: error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  seq_in carries a new symbol this cycle.
- seq_in  in  SYM_W  symbol under test (generator `out`).
- locked  out  1  high in LOCKED or SLIP.
- mismatch  out  1  one-cycle pulse per mismatching symbol while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.
- exp_idx  out  $clog2(SEQ_LEN)  table index of the next expected symbol.

Behaviour:
- All outputs are registered. Response appears the cycle after the sampled edge with in_valid=1. Cycles with in_valid=0 change nothing; mismatch=0 on those cycles.
- Reset (synchronous, any state, mid-operation included): state=HUNT, locked=0, mismatch=0, err_count=0, exp_idx=0, run/miss counters=0.
- FSM HUNT:
  - Without a seed, the sample is looked up in SEQ_TABLE. If found, exp_idx=(hit+1) mod SEQ_LEN, seeded=1, run=0. If not in the table, stay unseeded.
  - When seeded, sample==SEQ_TABLE[exp_idx] gives run+1 and exp_idx advances. On run reaching LOCK_CNT, go to LOCKED.
  - A seeded mismatch re-seeds from the current sample (table lookup, run=0).
  - No mismatch pulses or counting occur in HUNT.
- FSM LOCKED:
  - Match: exp_idx advances, wrapping SEQ_LEN-1 -> 0.
  - Mismatch: mismatch=1, err_count+1 (saturating at all-ones), exp_idx still advances, miss=1.
  - After a mismatch, go to SLIP; if UNLOCK_CNT==1, go directly to HUNT with the seed cleared.
- FSM SLIP:
  - Match: return to LOCKED, miss=0.
  - Mismatch: mismatch pulse, err_count+1, miss+1. When miss reaches UNLOCK_CNT, go to HUNT, locked=0, seed cleared.
  - exp_idx advances on every valid sample.
- Simultaneous events: lock-loss and mismatch in the same sample both take effect. That sample's mismatch is counted and locked falls on the same cycle.
- Index arithmetic is modulo SEQ_LEN, not modulo 2**width.

Optional Feature:
- Macro: SEQ_CHECKER_CAPTURE_EN.
- Defined:
  - Adds outputs err_exp[SYM_W-1:0], err_got[SYM_W-1:0] and err_seen[1].
  - These capture expected/actual values at the first mismatch after reset; later mismatches do not overwrite them.
  - All three reset to 0.
- Undefined: these ports and registers do not exist; the rest of the behaviour is unchanged.

Decomposition:
- Package seq_pkg holds:
  - the FSM state enum (HUNT, LOCKED, SLIP);
  - the default SEQ_TABLE constant;
  - a SYM_W localparam;
  - a function returning hit/index for a table lookup.
- One sub-module is natural: seq_lookup, a combinational symbol-to-index CAM over SEQ_TABLE with hit and idx outputs. It is used for seeding in HUNT.

Test Plan:
- Acquire lock: rst for 2 cycles, then feed 0,1,3,2,6 with in_valid=1.
  - locked rises the cycle after the "2" sample.
  - exp_idx=4 at that point; err_count=0; mismatch never pulses.
- Wrap-around: after lock, feed 7,5,4,0,1.
  - locked stays 1; exp_idx wraps 7 -> 0 after "4"; no mismatch.
- Single slip: locked, expecting 6, feed 5, then 7.
  - mismatch pulses once; err_count=1; state SLIP then back to LOCKED; locked held 1 throughout.
- Lock loss: locked, feed two wrong symbols consecutively.
  - Two mismatch pulses; err_count=2.
  - locked=0 the cycle after the second sample.
  - Re-feeding 5,4,0,1 relocks.
- Valid gating and reset mid-run: while locked, hold in_valid=0 for 5 cycles with garbage on seq_in.
  - No state change.
  - Then assert rst for one cycle: locked=0, err_count=0, exp_idx=0 the next cycle.
- Saturation, CNT_W=2 build: alternate locked mismatches and matches 5 times.
  - err_count reaches 3 and holds.
  - With SEQ_CHECKER_CAPTURE_EN, err_exp/err_got hold the first mismatch values.
